// File: rtl/teclado_emulador.sv
// 4x4 keypad emulator: answers the scanner's row drive with the column of a
// requested key, emulating press bounce, a held contact over N scans and a release gap.
module teclado_emulador #(
  parameter int BOUNCE_CYCLES = 4,
  parameter int HOLD_SCANS    = 3,
  parameter int GAP_CYCLES    = 8,
  parameter int HOLD_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] fila,
  output logic       col_0,
  output logic       col_1,
  output logic       col_2,
  output logic       col_3,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int BW = $clog2(BOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_SCANS) + 1;
  localparam int TW = $clog2(HOLD_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  localparam logic [BW-1:0] B_LAST = BW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_SCANS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(HOLD_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BOUNCE  = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    rsel_q, rsel_d;
  logic [1:0]    csel_q, csel_d;
  logic [BW-1:0] bounce_q, bounce_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [TW-1:0] to_q, to_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          row_q, row_d;
  logic          done_q, done_d;

  logic          accept, hit, contact, timeout_c;
  logic [3:0]    col_v;

  assign key_ready = (state_q == S_IDLE) && !rst;
  assign accept    = key_valid && key_ready;
  assign hit       = (state_q == S_HOLD) && row_q && !fila[rsel_q];

  always_comb begin
    contact = 1'b0;
    case (state_q)
      S_BOUNCE: contact = ~bounce_q[0];
      S_HOLD:   contact = 1'b1;
      default:  contact = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rsel_d    = rsel_q;
    csel_d    = csel_q;
    bounce_d  = bounce_q;
    hit_d     = hit_q;
    to_d      = to_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    timeout_c = 1'b0;
    // Level of the newly latched row on accept, so a pulse already in flight is seen correctly.
    row_d     = accept ? fila[key_code[3:2]] : fila[rsel_q];
    case (state_q)
      S_IDLE: if (accept) begin
        rsel_d   = key_code[3:2];
        csel_d   = key_code[1:0];
        bounce_d = '0;
        hit_d    = '0;
        to_d     = '0;
        gap_d    = '0;
        state_d  = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE;
      end
      S_BOUNCE: begin
        bounce_d = bounce_q + 1'b1;
        if (bounce_q == B_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        to_d = to_q + 1'b1;
        if (hit) hit_d = hit_q + 1'b1;
        // The final hit wins over a simultaneous timeout expiry.
        if (hit && hit_q == H_LAST) begin
          state_d = S_RELEASE;
        end else if (to_q == T_LAST) begin
          state_d   = S_RELEASE;
          timeout_c = 1'b1;
        end
      end
      default: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == G_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rsel_q   <= '0;
      csel_q   <= '0;
      bounce_q <= '0;
      hit_q    <= '0;
      to_q     <= '0;
      gap_q    <= '0;
      row_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsel_q   <= rsel_d;
      csel_q   <= csel_d;
      bounce_q <= bounce_d;
      hit_q    <= hit_d;
      to_q     <= to_d;
      gap_q    <= gap_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  // Combinational return path: the scanner reads the column in the cycle it drives the row.
  assign col_v   = {4{contact && fila[rsel_q] && !rst}} & (4'b0001 << csel_q);
  assign col_0   = col_v[0];
  assign col_1   = col_v[1];
  assign col_2   = col_v[2];
  assign col_3   = col_v[3];
  assign busy    = (state_q != S_IDLE) && !rst;
  assign done    = done_q && !rst;
  assign timeout = timeout_c && !rst;

endmodule

// File: doc/teclado_emulador.md
# teclado_emulador

Synthesizable 4x4 keypad emulator that sits on the far side of the calculator's row/column keypad interface. It receives key requests over a valid/ready handshake and watches the scanner's row drive `fila`. It then returns the matching column line exactly as a physical key would, with a contact-bounce burst, a hold of a fixed number of scan hits, and a release gap. It replaces the physical keypad in on-board self-test and drives `sistema_calculadora` from a host-side command source.

## Interface
Parameters:
- `BOUNCE_CYCLES`, 4: length of the press-edge chatter burst in clk cycles; 0 disables bounce.
- `HOLD_SCANS`, 3: completed scans of the key's row while the contact is held closed.
- `GAP_CYCLES`, 8: cycles with the contact open after hold, before the next key is accepted; minimum 1.
- `HOLD_TIMEOUT`, 1024: maximum HOLD duration in cycles.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `key_code` in 4: requested key; `[3:2]` is the row index, `[1:0]` is the column index.
- `key_valid` in 1: request valid.
- `key_ready` out 1: request accepted when `key_valid && key_ready` at a rising edge.
- `fila` in 4: row drive from the scanner, one-hot, active-high.
- `col_0`..`col_3` out 1 each: column returns, active-high.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a key sequence completes.
- `timeout` out 1: one-cycle pulse when HOLD ends by timeout.

## Operation
- Registered state: `state`, latched `row`/`col`, `bounce_cnt`, `hit_cnt`, `to_cnt`, `gap_cnt`, previous row level `row_q` (`row_q` = `fila[row]` sampled on the prior cycle).
- `contact` is combinational from `state`:
  - 0 in IDLE and RELEASE.
  - 1 in HOLD.
  - In BOUNCE it equals `~bounce_cnt[0]`: closed on the first bounce cycle, then alternating.
- Column output: `col_k = contact && (k == col) && fila[row] && !rst`. This path is combinational so the scanner samples the column in the same cycle the row is driven. Multiple hot `fila` bits are not checked; only `fila[row]` matters.
- `key_ready = (state == IDLE) && !rst`. `busy = (state != IDLE)`.
- FSM:
  - **IDLE**: on accept, latch `key_code` and clear all counters. Go to BOUNCE, or straight to HOLD if `BOUNCE_CYCLES == 0`.
  - **BOUNCE**: `bounce_cnt` increments each cycle. At `bounce_cnt == BOUNCE_CYCLES-1`, go to HOLD.
  - **HOLD**:
    - A hit is a falling edge of the row: `row_q == 1 && fila[row] == 0`. Each hit increments `hit_cnt`.
    - `to_cnt` increments every HOLD cycle.
    - When the `HOLD_SCANS`-th hit is seen, go to RELEASE.
    - Otherwise, if `to_cnt == HOLD_TIMEOUT-1`, go to RELEASE and pulse `timeout` for that one cycle.
  - **RELEASE**: `gap_cnt` increments. At `gap_cnt == GAP_CYCLES-1`, go to IDLE and assert `done` for the first IDLE cycle.
- Counter widths are sized by `$clog2` of their parameter plus 1. No counter wraps, because each one is cleared on entry to its state.

## Timing
- Reset values: state IDLE, all counters 0, `row_q` 0.
  - While `rst` is high: `col_*` = 0 (gated), `key_ready` = 0, `busy` = 0, `done` = 0, `timeout` = 0.
  - `key_ready` = 1 in the first cycle after `rst` falls.
- Reset mid-sequence: the column releases combinationally in the `rst` cycle. The FSM returns to IDLE at that edge, and no `done` or `timeout` pulse is produced.
- Accept at edge N: `busy` = 1 and `key_ready` = 0 from cycle N+1. The first contact-closed cycle is N+1.
- The bounce burst is exactly `BOUNCE_CYCLES` cycles, closed/open alternating, starting closed.
- A row pulse already in progress when HOLD is entered counts as a hit when it falls.
- If the last hit and timeout expiry occur in the same cycle, it is a normal completion: no `timeout` pulse.
- `key_valid` held high while busy is ignored. The same request is accepted on the first IDLE cycle, which is the same cycle `done` is high.
- Throughput floor: 1 + `BOUNCE_CYCLES` + HOLD duration + `GAP_CYCLES` cycles per key.

## Test plan
- **Reset**: hold `rst` 3 cycles with `fila` = 4'b1111 → all `col_*` = 0 and `key_ready` = 0. Release reset → `key_ready` = 1 the next cycle.
- **Basic key, 0x5**:
  - Setup: defaults, scanner rotating `fila` 0001→0010→0100→1000, each row held 4 cycles.
  - `col_1` = 1 only while `fila` = 0010.
  - Bounce pattern 1,0,1,0 is visible on `col_1` if row 1 is driven during BOUNCE.
  - `done` pulses after the 3rd fall of `fila[1]` plus 8 gap cycles.
- **No bounce**: with `BOUNCE_CYCLES` = 0 and key 0xF, `col_3` = 1 in the cycle after accept whenever `fila` = 1000. No open cycles occur during hold.
- **Timeout**: `HOLD_TIMEOUT` = 16, `fila` stuck at 0000, key 0x0 → `timeout` pulses once, `done` follows after `GAP_CYCLES` cycles, and `col_0` stays 0 throughout.
- **Reset mid-HOLD**: key 0xA during HOLD with `fila` = 0100 → `col_2` drops in the `rst` cycle. No `done` pulse, and `key_ready` = 1 after reset is released.
- **Back-to-back**: `key_valid` held high with 0x1 then 0x2 → the second key is accepted on the `done` cycle, and the columns never overlap.
